// File: rtl/puzzle3_2_pkg.sv
// Shared types and helpers for the puzzle3_2 maximum-joltage accumulator.
package puzzle3_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  // x*10 as (x<<3)+(x<<1); callers truncate to their own width.
  function automatic logic [63:0] mul10(input logic [63:0] x);
    return (x << 3) + (x << 1);
  endfunction

  // 10^k - 1, the largest k-digit decimal value.
  function automatic logic [63:0] max_val(input int unsigned k);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < k; i++) begin
      p = mul10(p);
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/puzzle3_2_if.sv
// Digit stream in / bank results out for puzzle3_2; sum_ovf exists only with PUZZLE3_OVF_EN.
interface puzzle3_2_if
  import puzzle3_pkg::*;
#(
  parameter int unsigned VAL_W = 40,
  parameter int unsigned SUM_W = 64
);
  digit_t             data_in;
  logic               wr_en;
  logic               bank_end;
  logic [VAL_W-1:0]   bank_max;
  logic               bank_valid;
  logic               short_bank;
  logic [SUM_W-1:0]   sum;
`ifdef PUZZLE3_OVF_EN
  logic               sum_ovf;
`endif

  modport master (
    output data_in, wr_en, bank_end,
    input  bank_max, bank_valid, short_bank, sum
`ifdef PUZZLE3_OVF_EN
    , sum_ovf
`endif
  );

  modport slave (
    input  data_in, wr_en, bank_end,
    output bank_max, bank_valid, short_bank, sum
`ifdef PUZZLE3_OVF_EN
    , sum_ovf
`endif
  );
endinterface

// File: rtl/puzzle3_bank_max.sv
// Per-bank DP: best[j] is the largest j-digit subsequence of the bank so far.
module puzzle3_bank_max
  import puzzle3_pkg::*;
#(
  parameter int unsigned DIGITS = 12,
  parameter int unsigned VAL_W  = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  digit_t           digit_i,
  input  logic             wr_en_i,
  input  logic             bank_end_i,
  output logic [VAL_W-1:0] close_val_o,
  output logic             close_o,
  output logic             short_o
);

  if (DIGITS < 1 || VAL_W > 64 || (VAL_W < 64 && (max_val(DIGITS) >> VAL_W) != 64'd0)) begin : g_bad_cfg
    $error("puzzle3_bank_max: VAL_W cannot hold DIGITS digits");
  end

  logic [VAL_W-1:0] best_q [DIGITS];
  logic [VAL_W-1:0] best_d [DIGITS];
  logic [DIGITS-1:0] v_q, v_d;

  // prev_best[j]/prev_v[j] describe the j-digit entry, with entry 0 fixed at value 0, valid.
  logic [VAL_W-1:0] prev_best [DIGITS+1];
  logic [DIGITS:0]  prev_v;
  logic             accept;
  logic [VAL_W-1:0] cand;

  assign accept = wr_en_i && (digit_i <= digit_t'(9));
  assign close_o = wr_en_i && bank_end_i;

  always_comb begin
    prev_best[0] = '0;
    prev_v       = {v_q, 1'b1};
    for (int unsigned i = 0; i < DIGITS; i++) begin
      prev_best[i+1] = best_q[i];
    end
    cand = '0;
    v_d  = v_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      best_d[i] = best_q[i];
      if (accept && prev_v[i]) begin
        cand = VAL_W'(mul10(64'(prev_best[i]))) + VAL_W'(digit_i);
        if (!v_q[i] || cand > best_q[i]) begin
          best_d[i] = cand;
        end
        v_d[i] = 1'b1;
      end
    end
    close_val_o = v_d[DIGITS-1] ? best_d[DIGITS-1] : '0;
    short_o     = close_o && !v_d[DIGITS-1];
  end

  always_ff @(posedge clk) begin
    if (rst || close_o) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        best_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        best_q[i] <= best_d[i];
      end
    end
  end

endmodule

// File: rtl/puzzle3_2.sv
// Streaming maximum-joltage accumulator: registers per-bank results and sums them.
// Optional sticky carry-out flag sum_ovf with PUZZLE3_OVF_EN.
module puzzle3_2
  import puzzle3_pkg::*;
#(
  parameter int unsigned DIGITS = 12,
  parameter int unsigned VAL_W  = 40,
  parameter int unsigned SUM_W  = 64
) (
  input logic        clk,
  input logic        rst,
  puzzle3_2_if.slave bus
);

  logic [VAL_W-1:0] close_val;
  logic             close, close_short;

  puzzle3_bank_max #(.DIGITS(DIGITS), .VAL_W(VAL_W)) u_bank (
    .clk        (clk),
    .rst        (rst),
    .digit_i    (bus.data_in),
    .wr_en_i    (bus.wr_en),
    .bank_end_i (bus.bank_end),
    .close_val_o(close_val),
    .close_o    (close),
    .short_o    (close_short)
  );

  logic [VAL_W-1:0] bank_max_q, bank_max_d;
  logic             bank_valid_q, bank_valid_d;
  logic             short_q, short_d;
  logic [SUM_W-1:0] sum_q, sum_d;
`ifdef PUZZLE3_OVF_EN
  logic             ovf_q, ovf_d;
  logic [SUM_W:0]   acc;
`endif

  always_comb begin
    bank_max_d   = close ? close_val : bank_max_q;
    bank_valid_d = close;
    short_d      = close_short;
    sum_d        = sum_q;
`ifdef PUZZLE3_OVF_EN
    ovf_d = ovf_q;
    acc   = {1'b0, sum_q} + {1'b0, SUM_W'(bank_max_q)};
    if (bank_valid_q) begin
      sum_d = acc[SUM_W-1:0];
      ovf_d = ovf_q | acc[SUM_W];
    end
`else
    if (bank_valid_q) begin
      sum_d = sum_q + SUM_W'(bank_max_q);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_max_q   <= '0;
      bank_valid_q <= 1'b0;
      short_q      <= 1'b0;
      sum_q        <= '0;
`ifdef PUZZLE3_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      bank_max_q   <= bank_max_d;
      bank_valid_q <= bank_valid_d;
      short_q      <= short_d;
      sum_q        <= sum_d;
`ifdef PUZZLE3_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign bus.bank_max   = bank_max_q;
  assign bus.bank_valid = bank_valid_q;
  assign bus.short_bank = short_q;
  assign bus.sum        = sum_q;
`ifdef PUZZLE3_OVF_EN
  assign bus.sum_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_puzzle3_2.sv
// Directed bench for puzzle3_2: four instances (K=2, K=12, K=3, K=2 with 8-bit sum) share one digit stream.
module tb_puzzle3_2;
  import puzzle3_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  digit_t tb_d = '0;
  logic   tb_we = 1'b0;
  logic   tb_be = 1'b0;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  puzzle3_2_if #(.VAL_W(40), .SUM_W(64)) if2 ();
  puzzle3_2_if #(.VAL_W(40), .SUM_W(64)) if12 ();
  puzzle3_2_if #(.VAL_W(40), .SUM_W(64)) if3 ();
  puzzle3_2_if #(.VAL_W(8),  .SUM_W(8))  if8 ();

  assign if2.data_in  = tb_d;  assign if2.wr_en  = tb_we; assign if2.bank_end  = tb_be;
  assign if12.data_in = tb_d;  assign if12.wr_en = tb_we; assign if12.bank_end = tb_be;
  assign if3.data_in  = tb_d;  assign if3.wr_en  = tb_we; assign if3.bank_end  = tb_be;
  assign if8.data_in  = tb_d;  assign if8.wr_en  = tb_we; assign if8.bank_end  = tb_be;

  puzzle3_2 #(.DIGITS(2),  .VAL_W(40), .SUM_W(64)) u_k2  (.clk(clk), .rst(rst), .bus(if2));
  puzzle3_2 #(.DIGITS(12), .VAL_W(40), .SUM_W(64)) u_k12 (.clk(clk), .rst(rst), .bus(if12));
  puzzle3_2 #(.DIGITS(3),  .VAL_W(40), .SUM_W(64)) u_k3  (.clk(clk), .rst(rst), .bus(if3));
  puzzle3_2 #(.DIGITS(2),  .VAL_W(8),  .SUM_W(8))  u_s8  (.clk(clk), .rst(rst), .bus(if8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input logic we, input digit_t d, input logic be);
    tb_we = we;
    tb_d  = d;
    tb_be = be;
    @(posedge clk);
    #1;
    tb_we = 1'b0;
    tb_be = 1'b0;
  endtask

  // ':' encodes the out-of-range digit 0xA.
  task automatic send_bank(input string s);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, digit_t'(s[i] - 8'h30), i == s.len() - 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_bank_max",   64'(if2.bank_max), 0);
    chk("rst_bank_valid", 64'(if2.bank_valid), 0);
    chk("rst_short",      64'(if12.short_bank), 0);
    chk("rst_sum",        64'(if12.sum), 0);

    // Four banks, K=2 and K=12
    send_bank("987654321111111");
    chk("b1_valid", 64'(if2.bank_valid), 1);
    chk("b1_k2",    64'(if2.bank_max), 98);
    chk("b1_k12",   64'(if12.bank_max), 64'd987654321111);
    step(1'b0, '0, 1'b0);
    chk("b1_valid_drop", 64'(if2.bank_valid), 0);
    chk("b1_sum_k2", 64'(if2.sum), 98);
    send_bank("811111111111119");
    chk("b2_k2",  64'(if2.bank_max), 89);
    chk("b2_k12", 64'(if12.bank_max), 64'd811111111119);
    send_bank("234234234234278");
    chk("b3_k2",  64'(if2.bank_max), 78);
    chk("b3_k12", 64'(if12.bank_max), 64'd434234234278);
    send_bank("818181911112111");
    chk("b4_k2",  64'(if2.bank_max), 92);
    chk("b4_k12", 64'(if12.bank_max), 64'd888911112111);
    chk("b4_short_k12", 64'(if12.short_bank), 0);
    step(1'b0, '0, 1'b0);
    chk("sum_k2",  64'(if2.sum), 357);
    chk("sum_k12", 64'(if12.sum), 64'd3121910778619);
    chk("sum_s8_wrap", 64'(if8.sum), 101);
`ifdef PUZZLE3_OVF_EN
    chk("ovf_s8_four_banks", 64'(if8.sum_ovf), 1);
`endif

    // Short bank then back-to-back bank, K=3
    do_reset();
    send_bank("91");
    chk("short_k3",       64'(if3.short_bank), 1);
    chk("short_valid_k3", 64'(if3.bank_valid), 1);
    chk("short_max_k3",   64'(if3.bank_max), 0);
    chk("short_flag_k2",  64'(if2.short_bank), 0);
    chk("short_max_k2",   64'(if2.bank_max), 91);
    send_bank("123");
    chk("b2b_k3",      64'(if3.bank_max), 123);
    chk("b2b_short_k3", 64'(if3.short_bank), 0);
    chk("b2b_k2",      64'(if2.bank_max), 23);
    step(1'b0, '0, 1'b0);
    chk("b2b_sum_k3", 64'(if3.sum), 123);
    chk("b2b_sum_k2", 64'(if2.sum), 114);

    // Reset mid-bank
    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'd7, 1'b0);
    do_reset();
    chk("mid_rst_max",   64'(if2.bank_max), 0);
    chk("mid_rst_valid", 64'(if2.bank_valid), 0);
    chk("mid_rst_short", 64'(if2.short_bank), 0);
    chk("mid_rst_sum",   64'(if2.sum), 0);
    send_bank("34");
    chk("mid_rst_b_max", 64'(if2.bank_max), 34);
    step(1'b0, '0, 1'b0);
    chk("mid_rst_b_sum", 64'(if2.sum), 34);

    // Invalid digit mid-bank; bank_end without wr_en
    do_reset();
    send_bank("1:9");
    chk("bad_digit_k2",  64'(if2.bank_max), 19);
    chk("bad_digit_k3_short", 64'(if3.short_bank), 1);
    step(1'b0, '0, 1'b1);
    chk("be_no_we_sum", 64'(if2.sum), 19);
    step(1'b0, '0, 1'b1);
    chk("be_no_we_valid", 64'(if2.bank_valid), 0);
    chk("be_no_we_sum2",  64'(if2.sum), 19);
    chk("be_no_we_max",   64'(if2.bank_max), 19);

    // Wrap of an 8-bit sum
    do_reset();
    send_bank("99");
    step(1'b0, '0, 1'b0);
    chk("s8_sum1", 64'(if8.sum), 99);
    send_bank("99");
    step(1'b0, '0, 1'b0);
    chk("s8_sum2", 64'(if8.sum), 198);
`ifdef PUZZLE3_OVF_EN
    chk("s8_ovf2", 64'(if8.sum_ovf), 0);
`endif
    send_bank("99");
    step(1'b0, '0, 1'b0);
    chk("s8_sum3", 64'(if8.sum), 41);
`ifdef PUZZLE3_OVF_EN
    chk("s8_ovf3", 64'(if8.sum_ovf), 1);
    repeat (3) step(1'b0, '0, 1'b0);
    chk("s8_ovf_hold", 64'(if8.sum_ovf), 1);
    do_reset();
    chk("s8_ovf_rst", 64'(if8.sum_ovf), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/puzzle3_2.md
# puzzle3_2

Streaming maximum-joltage accumulator, a parametrised successor to the two-digit puzzle3 solver. Consumes a stream of decimal digits grouped into banks. For each bank it selects exactly `DIGITS` digits, in order, forming the largest possible `DIGITS`-digit number, and adds it to a running total. It sits directly behind the file-reader/stimulus front end and drives the final `sum` result.

## Interface
Parameters:
- `DIGITS`, 12: digits selected per bank (K ≥ 1).
- `VAL_W`, 40: width of a per-bank value; must hold 10^DIGITS − 1.
- `SUM_W`, 64: accumulator width.

Ports:
- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `data_in`  in  4  — digit 0–9, sampled when `wr_en`.
- `wr_en`  in  1  — digit valid this cycle.
- `bank_end`  in  1  — this digit is the last of its bank; qualified by `wr_en`.
- `bank_max`  out  VAL_W  — best K-digit value of the most recent bank.
- `bank_valid`  out  1  — one-cycle pulse: `bank_max` updated.
- `short_bank`  out  1  — one-cycle pulse alongside `bank_valid`: bank had fewer than K digits and contributed 0.
- `sum`  out  SUM_W  — running total.
- `sum_ovf`  out  1  — sticky overflow; present only with `PUZZLE3_OVF_EN`.

## Operation
- DP registers `best[1..K]` (VAL_W each) plus valid bits `v[1..K]`. `best[j]` is the largest j-digit subsequence of the bank prefix.
- On an accepted digit d, all j update in parallel from old values:
  - `cand_j = best[j-1]*10 + d`, with `best[0]=0` and `v[0]=1`.
  - If `v[j-1]`: `best[j] = v[j] ? max(best[j], cand_j) : cand_j`, and `v[j]=1`.
- ×10 is implemented as `(x<<3)+(x<<1)`, truncated to VAL_W.
- Accepted digit with value > 9: ignored, with no DP change. If it also carries `bank_end`, the bank still closes.
- Bank close (`wr_en && bank_end`):
  - The updated `best[K]` (including the closing digit) is captured into `bank_max`, or 0 if the updated `v[K]=0`.
  - All `best`/`v` are cleared at the same edge.
- Accumulate: `sum <= sum + bank_max` in the cycle `bank_valid` is high. Width is SUM_W; wraps modulo 2^SUM_W.
- `bank_end` with `wr_en=0`: ignored.
- Reset clears all state: `best`, `v`, `bank_max=0`, `bank_valid=0`, `short_bank=0`, `sum=0`, `sum_ovf=0`.
- Reset asserted mid-bank discards the partial bank; no contribution to `sum`.

## Timing
- Digit accepted at edge N updates the DP at edge N.
- Closing digit at edge N:
  - `bank_max`, `bank_valid`, `short_bank` valid after edge N (cycle N+1).
  - `sum` reflects the bank after edge N+1.
- Throughput is one digit per cycle. Back-to-back banks are allowed: the first digit of the next bank may arrive at edge N+1 and sees cleared DP.
- No backpressure; the block is always ready.
- `bank_valid` never asserts on consecutive cycles unless banks are one digit long. Each pulse is still accumulated exactly once.

## Configuration
- `PUZZLE3_OVF_EN` defined:
  - `sum_ovf` port exists.
  - Set when an accumulate carries out of bit SUM_W−1; held until `rst`.
  - `sum` still wraps.
- `PUZZLE3_OVF_EN` undefined: no `sum_ovf` port and no carry logic; `sum` wraps silently.

## Structure
- Package `puzzle3_pkg` contains:
  - `DIGIT_W=4`
  - `typedef logic [3:0] digit_t`
  - function `mul10`
  - function `max_val(K)` for static `VAL_W` checks
- Sub-module `puzzle3_bank_max` holds the `best`/`v` DP array and close logic. Outputs: closing value, valid, short flag.
- Top `puzzle3_2` holds the output registers, the accumulator and the optional overflow flag.

## Test plan
- K=2, banks "987654321111111", "811111111111119", "234234234234278", "818181911112111", each closed on the last digit → `bank_max` 98, 89, 78, 92; final `sum`=357.
- K=12, same four banks → `bank_max` 987654321111, 811111111119, 434234234278, 888911112111; `sum`=3121910778619.
- K=3, bank "91" → `short_bank` pulse, `bank_max`=0, `sum` unchanged. Next bank "123" back-to-back → `bank_max`=123.
- K=2, digits 5,7 then `rst` before `bank_end`, then bank "34" → `sum`=34; all outputs 0 for the cycle after reset.
- K=2, bank "1:9" (0xA digit mid-bank) → `bank_max`=19; `bank_end` with `wr_en=0` produces no pulse.
- `PUZZLE3_OVF_EN`, SUM_W=8, K=2, banks "99","99","99" → `sum`=41 (297 mod 256), `sum_ovf`=1 after the third accumulate, stays 1 until `rst`.
